// File: rtl/eth_frame_detector_pkg.sv
// ---------------------------------------------------------------------------
// eth_frame_detector_pkg
// Shared constants and types for the Ethernet frame detector result stage and
// the downstream register/log block.
//   state_e      : per-direction frame tracking state (IDLE / CAPTURE / DROP)
//   C_EXT_MAX    : largest supported number of extraction bytes per frame
//   C_*_W        : field widths of the published result
// ---------------------------------------------------------------------------
package eth_frame_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    localparam int unsigned C_EXT_MAX     = 16;
    localparam int unsigned C_PAT_W       = 4;
    localparam int unsigned C_ID_W        = 2;
    localparam int unsigned C_EXT_NUM_W   = 5;
    localparam int unsigned C_EXT_DATA_W  = 128;

endpackage

// File: rtl/eth_frame_detector_result_if.sv
// ---------------------------------------------------------------------------
// eth_frame_detector_result_if
// Groups the comparator byte stream (towards the result stage) and the
// published result (towards the register/log block).
//   frame_valid/last/error, pattern_match, ext_en, ext_byte : byte stream
//   match, match_id, match_ext_num, match_ext_data           : result
// Modports:
//   master : drives the byte stream, observes the result
//   slave  : the result stage itself
// ---------------------------------------------------------------------------
interface eth_frame_detector_result_if;
    import eth_frame_detector_pkg::*;

    logic                     frame_valid;
    logic                     frame_last;
    logic                     frame_error;
    logic [C_PAT_W-1:0]       pattern_match;
    logic                     ext_en;
    logic [7:0]               ext_byte;

    logic [C_PAT_W-1:0]       match;
    logic [C_ID_W-1:0]        match_id;
    logic [C_EXT_NUM_W-1:0]   match_ext_num;
    logic [C_EXT_DATA_W-1:0]  match_ext_data;

    modport master (
        output frame_valid, frame_last, frame_error, pattern_match, ext_en, ext_byte,
        input  match, match_id, match_ext_num, match_ext_data
    );

    modport slave (
        input  frame_valid, frame_last, frame_error, pattern_match, ext_en, ext_byte,
        output match, match_id, match_ext_num, match_ext_data
    );

endinterface

// File: rtl/eth_frame_detector_ext_buffer.sv
// ---------------------------------------------------------------------------
// eth_frame_detector_ext_buffer
// Collects flagged extraction bytes of one frame into byte lanes.
//   clk, rst (async, active-high), srst (sync soft reset)
//   wr_en    : byte present and flagged for extraction
//   wr_byte  : byte value
//   clr      : end of frame; buffer and count return to zero after this cycle
//   num_mrg  : byte count including this cycle's write (combinational)
//   data_mrg : lanes including this cycle's write (combinational)
// The merged outputs let the parent publish a byte that arrives on the last
// beat in the same cycle the buffer is cleared.
// ---------------------------------------------------------------------------
module eth_frame_detector_ext_buffer
    import eth_frame_detector_pkg::*;
#(
    parameter int unsigned C_EXT_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    srst,
    input  logic                    wr_en,
    input  logic [7:0]              wr_byte,
    input  logic                    clr,
    output logic [C_EXT_NUM_W-1:0]  num_mrg,
    output logic [C_EXT_DATA_W-1:0] data_mrg
);

    logic [C_EXT_MAX-1:0][7:0] lane_q, lane_d, lane_mrg;
    logic [C_EXT_NUM_W-1:0]    count_q, count_d;
    logic [C_EXT_MAX-1:0]      lane_we;
    logic                      wr_ok;

    always_comb begin
        // Saturate: bytes beyond C_EXT_BYTES are dropped silently.
        wr_ok   = wr_en && (count_q < C_EXT_NUM_W'(C_EXT_BYTES));
        lane_we = '0;
        for (int unsigned i = 0; i < C_EXT_MAX; i++) begin
            lane_we[i] = wr_ok && (count_q == C_EXT_NUM_W'(i));
        end
        lane_mrg = lane_q;
        for (int unsigned i = 0; i < C_EXT_MAX; i++) begin
            if (lane_we[i]) begin
                lane_mrg[i] = wr_byte;
            end
        end
        num_mrg  = wr_ok ? count_q + 1'b1 : count_q;
        data_mrg = lane_mrg;
        count_d  = clr ? '0 : num_mrg;
        lane_d   = clr ? '0 : lane_mrg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            count_q <= '0;
        end else if (srst) begin
            lane_q  <= '0;
            count_q <= '0;
        end else begin
            lane_q  <= lane_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/eth_frame_detector_result.sv
// ---------------------------------------------------------------------------
// eth_frame_detector_result
// Result stage of the Ethernet frame detector (one instance per direction).
// Tracks frame state, collects extraction bytes and, at the end of a good
// frame with at least one enabled pattern match, publishes the masked match
// flags, the extracted bytes and a rolling 2-bit event ID.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   srst      : synchronous soft reset, same effect as rst
//   match_en  : per-pattern enable, sampled on the last beat only
//   fd        : byte stream in / registered result out (slave modport)
// Outputs change only on a publish and are held otherwise.
// ---------------------------------------------------------------------------
module eth_frame_detector_result
    import eth_frame_detector_pkg::*;
#(
    parameter int unsigned C_EXT_BYTES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                srst,
    input  logic [C_PAT_W-1:0]  match_en,
    eth_frame_detector_result_if.slave fd
);

    state_e                   state_q, state_d;
    logic [C_PAT_W-1:0]       match_q, match_d;
    logic [C_ID_W-1:0]        match_id_q, match_id_d;
    logic [C_EXT_NUM_W-1:0]   ext_num_q, ext_num_d;
    logic [C_EXT_DATA_W-1:0]  ext_data_q, ext_data_d;

    logic [C_PAT_W-1:0]       m;
    logic                     errored;
    logic                     publish;
    logic [C_EXT_NUM_W-1:0]   num_mrg;
    logic [C_EXT_DATA_W-1:0]  data_mrg;
    logic                     eof;
    logic                     wr_en;

    assign eof   = fd.frame_valid & fd.frame_last;
    assign wr_en = fd.frame_valid & fd.ext_en;

    eth_frame_detector_ext_buffer #(
        .C_EXT_BYTES (C_EXT_BYTES)
    ) u_ext_buffer (
        .clk      (clk),
        .rst      (rst),
        .srst     (srst),
        .wr_en    (wr_en),
        .wr_byte  (fd.ext_byte),
        .clr      (eof),
        .num_mrg  (num_mrg),
        .data_mrg (data_mrg)
    );

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        match_id_d = match_id_q;
        ext_num_d  = ext_num_q;
        ext_data_d = ext_data_q;
        m          = fd.pattern_match & match_en;
        // An error on the last beat itself also spoils the frame.
        errored    = (state_q == ST_DROP) || fd.frame_error;
        publish    = 1'b0;

        if (fd.frame_valid) begin
            case (state_q)
                ST_IDLE:    state_d = fd.frame_error ? ST_DROP : ST_CAPTURE;
                ST_CAPTURE: if (fd.frame_error) state_d = ST_DROP;
                ST_DROP:    state_d = ST_DROP;
                default:    state_d = ST_IDLE;
            endcase
            if (fd.frame_last) begin
                state_d = ST_IDLE;
                publish = !errored && (m != '0);
            end
        end

        if (publish) begin
            match_d    = m;
            match_id_d = match_id_q + 1'b1;
            ext_num_d  = num_mrg;
            ext_data_d = data_mrg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            match_q    <= '0;
            match_id_q <= '0;
            ext_num_q  <= '0;
            ext_data_q <= '0;
        end else if (srst) begin
            state_q    <= ST_IDLE;
            match_q    <= '0;
            match_id_q <= '0;
            ext_num_q  <= '0;
            ext_data_q <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            match_id_q <= match_id_d;
            ext_num_q  <= ext_num_d;
            ext_data_q <= ext_data_d;
        end
    end

    assign fd.match          = match_q;
    assign fd.match_id       = match_id_q;
    assign fd.match_ext_num  = ext_num_q;
    assign fd.match_ext_data = ext_data_q;

endmodule
